exception_ctrl: RTL
===================

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 Parameter N, default 64: PC/data width in bits.
REQ-002 Parameter NSRC, default 4: number of exception sources, legal range 1..15.
REQ-003 Parameter VBASE, default 64'hD8: exception vector base address.
REQ-004 Parameter VECTORED, default 0: 0 gives a single vector; 1 gives a per-source vector.
REQ-005 clk  in  1  system clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 Exc  in  NSRC  level-sensitive exception requests; bit i is source i.
REQ-008 ERet  in  1  ERET instruction in execution.
REQ-009 NextPC_X  in  N  PC+4 of the current instruction.
REQ-010 imem_addr_X  in  N  PC of the current instruction.
REQ-011 ALUBranch_X  in  N  normal branch target from execute.
REQ-012 EDataSel  in  2  system-register read select (MRS).
REQ-013 MaskWe  in  1  mask write enable.
REQ-014 MaskWData  in  NSRC  new mask value; bit=1 masks the source.
REQ-015 EProc_X  out  1  take exception this cycle; fetch loads EVAddr_X.
REQ-016 EVAddr_X  out  N  vector address.
REQ-017 PCBranch_X  out  N  branch target to fetch.
REQ-018 readData_X  out  N  system-register read data.
REQ-019 ExcAck  out  1  one-cycle acknowledge of a taken exception.
REQ-020 InHandler  out  1  high while in HANDLER state.
REQ-021 ExcPending  out  1  at least one unmasked request is not being taken.

Function
REQ-022 The module SHALL have two states, IDLE and HANDLER.
REQ-023 pend = Exc & ~mask; the winner SHALL be the lowest-index set bit of pend.
REQ-024 EProc_X SHALL equal 1 combinationally when the state is IDLE and pend != 0; otherwise 0.
REQ-025 EVAddr_X SHALL be VBASE when VECTORED=0, and VBASE + (winner << 7) when VECTORED=1; the value is don't-care when EProc_X=0.
REQ-026 On an edge with EProc_X=1, the following SHALL load, and the state SHALL go to HANDLER:
- ELR <= NextPC_X
- ERR <= imem_addr_X
- ESR <= winner+1 (4 bits)
REQ-027 ExcAck SHALL be registered and high exactly for the first HANDLER cycle after a take.
REQ-028 In HANDLER, further requests SHALL NOT be taken (no nesting), and ELR/ERR/ESR SHALL hold.
REQ-029 ExcPending SHALL be (pend != 0) && state==HANDLER.
REQ-030 PCBranch_X SHALL be ELR when ERet=1 and state==HANDLER; otherwise ALUBranch_X.
REQ-031 On an edge with ERet=1 in HANDLER, the state SHALL go to IDLE.
REQ-032 ERet in IDLE SHALL have no effect on state.
REQ-033 When ERet and a pending request coincide in HANDLER, the module SHALL return to IDLE; a still-asserted request SHALL be taken in the next cycle.
REQ-034 readData_X SHALL be selected combinationally by EDataSel, zero-extended to N:
- 00: ELR
- 01: ESR
- 10: ERR
- 11: mask
REQ-035 The mask SHALL load MaskWData on an edge with MaskWe=1, in any state; the take decision in that same cycle SHALL use the old mask.
REQ-036 A request deasserted before an edge SHALL be lost; sources SHALL hold requests until ExcAck.

Reset
REQ-037 On an edge with reset=1, the state SHALL go to IDLE, and ELR, ERR, ESR, mask and ExcAck SHALL all be 0; reset SHALL override a simultaneous take, ERet or MaskWe.
REQ-038 During reset cycles EProc_X SHALL be 0 regardless of Exc.
REQ-039 Reset mid-handler SHALL abandon the handler with no return.

Verification
REQ-040 Single take: Exc=4'b0100, PC=0x40, NextPC=0x44, VECTORED=0 -> EProc_X=1 and EVAddr_X=0xD8 that cycle; next cycle ExcAck=1, InHandler=1; EDataSel=00/01/10 read 0x44/3/0x40.
REQ-041 Priority and vectoring: VECTORED=1, Exc=4'b1010 -> winner 1, EVAddr_X=0x158, ESR=2.
REQ-042 Masking and pending: mask=4'b0001 written, then Exc=4'b0001 -> no take and EProc_X=0; then Exc=4'b0011 -> take source 1; in HANDLER with Exc=4'b0011 -> ExcPending=1 and no second ExcAck.
REQ-043 ERet with queued request: in HANDLER with ELR=0x44, ERet=1 and Exc=4'b0001 held -> PCBranch_X=0x44 that cycle; one IDLE cycle with an immediate retake (EProc_X=1); ELR updated.
REQ-044 ERet in IDLE: ALUBranch_X=0x100, ERet=1 -> PCBranch_X=0x100, state remains IDLE.
REQ-045 Reset mid-handler: reset=1 while InHandler=1 -> next cycle state IDLE, all registers 0, ExcAck=0, no EProc_X even with Exc asserted during reset.

Source files
------------

// File: rtl/exception_ctrl.sv
// Exception controller: picks the lowest-index unmasked request, vectors fetch, saves ELR/ERR/ESR, returns on ERET.
// Latency: take decision and vector are combinational; ELR/ERR/ESR, state and ExcAck update on the next edge.
// Backpressure: none; sources hold requests until ExcAck, and nothing is taken while a handler is running.
module exception_ctrl #(
    parameter int          N        = 64,
    parameter int          NSRC     = 4,
    parameter logic [N-1:0] VBASE   = N'(64'hD8),
    parameter bit          VECTORED = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] Exc,
    input  logic            ERet,
    input  logic [N-1:0]    NextPC_X,
    input  logic [N-1:0]    imem_addr_X,
    input  logic [N-1:0]    ALUBranch_X,
    input  logic [1:0]      EDataSel,
    input  logic            MaskWe,
    input  logic [NSRC-1:0] MaskWData,
    output logic            EProc_X,
    output logic [N-1:0]    EVAddr_X,
    output logic [N-1:0]    PCBranch_X,
    output logic [N-1:0]    readData_X,
    output logic            ExcAck,
    output logic            InHandler,
    output logic            ExcPending
);

    typedef enum logic {IDLE = 1'b0, HANDLER = 1'b1} state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    elr, err;
    logic [3:0]      esr;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] pend;
    logic [3:0]      winner;
    logic            take;
    logic            exc_ack;

    assign pend = Exc & ~mask;

    // Walk downward so the lowest set bit is the last assignment to stick.
    always_comb begin
        winner = 4'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend[i]) winner = 4'(i);
        end
    end

    // Reset gates the take so nothing can be vectored while reset is held.
    assign take = (state == IDLE) && (|pend) && !reset;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = HANDLER;
            HANDLER: if (ERet) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        EProc_X    = take;
        InHandler  = (state == HANDLER);
        ExcPending = (state == HANDLER) && (|pend);
        PCBranch_X = ((state == HANDLER) && ERet) ? elr : ALUBranch_X;
        if (VECTORED) EVAddr_X = VBASE + (N'(winner) << 7);
        else          EVAddr_X = VBASE;
    end

    always_comb begin
        case (EDataSel)
            2'b00:   readData_X = elr;
            2'b01:   readData_X = N'(esr);
            2'b10:   readData_X = err;
            default: readData_X = N'(mask);
        endcase
    end

    // The mask write lands on the same edge as a take, so the take above sees the old mask.
    always_ff @(posedge clk) begin
        if (reset) begin
            elr     <= '0;
            err     <= '0;
            esr     <= 4'd0;
            mask    <= '0;
            exc_ack <= 1'b0;
        end else begin
            if (take) begin
                elr <= NextPC_X;
                err <= imem_addr_X;
                esr <= winner + 4'd1;
            end
            if (MaskWe) mask <= MaskWData;
            exc_ack <= take;
        end
    end

    assign ExcAck = exc_ack;

endmodule
